// File: rtl/cpu_pkg.sv
// Shared constants for the multicycle CPU control sequencer: opcodes, states, field positions.
// Used by cpu_seq_ctrl (optional stall port enabled with macro CPU_SEQ_STALL_EN).
package cpu_pkg;

  localparam int IW_DEFAULT   = 16;
  localparam int NREG_DEFAULT = 8;

  localparam logic [2:0] OP_MV   = 3'b000;
  localparam logic [2:0] OP_MVI  = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_XOR  = 3'b100;
  localparam logic [2:0] OP_JR   = 3'b101;
  localparam logic [2:0] OP_HALT = 3'b110;
  localparam logic [2:0] OP_NOP  = 3'b111;

  localparam int OPC_MSB = 15;
  localparam int OPC_LSB = 13;
  localparam int RX_MSB  = 12;
  localparam int RX_LSB  = 10;
  localparam int RY_MSB  = 9;
  localparam int RY_LSB  = 7;
  localparam int IMM_MSB = 9;
  localparam int IMM_LSB = 0;

  typedef enum logic [2:0] {
    S_FETCH = 3'd0,
    S_T1    = 3'd1,
    S_T2    = 3'd2,
    S_T3    = 3'd3,
    S_HALT  = 3'd4
  } state_t;

  function automatic logic is_alu_op(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_XOR);
  endfunction

endpackage

// File: rtl/dec3to8.sv
// Combinational 3-to-8 one-hot decoder with enable; all outputs low when disabled.
module dec3to8 #(
  parameter int NOUT = 8
) (
  input  logic            en,
  input  logic [2:0]      sel,
  output logic [NOUT-1:0] y
);

  always_comb begin
    y = '0;
    if (en) begin
      y[sel] = 1'b1;
    end
  end

endmodule

// File: rtl/cpu_seq_ctrl.sv
// Multicycle control sequencer: latches one instruction per handshake and drives datapath strobes.
// Define CPU_SEQ_STALL_EN to add a 'stall' input that freezes the sequencer and zeroes all outputs.
module cpu_seq_ctrl
  import cpu_pkg::*;
#(
  parameter int IW   = 16,
  parameter int NREG = 8
) (
  input  logic            clk,
  input  logic            resetn,
`ifdef CPU_SEQ_STALL_EN
  input  logic            stall,
`endif
  input  logic [IW-1:0]   instr,
  input  logic            instr_valid,
  output logic            instr_ready,
  output logic            pc_inc,
  output logic [NREG-1:0] rin,
  output logic [NREG-1:0] rout,
  output logic            ain,
  output logic            gin,
  output logic            gout,
  output logic            pcin,
  output logic            immout,
  output logic            addsub,
  output logic            xorctrl,
  output logic            done,
  output logic            halted
);

  state_t        state_q, state_d;
  logic [IW-1:0] ir_q, ir_d;

  logic [2:0] op, rx, ry;
  logic       stall_w;
  logic       rin_en, rout_en;
  logic [2:0] rout_sel;
  logic       accept;

  assign op = ir_q[OPC_MSB:OPC_LSB];
  assign rx = ir_q[RX_MSB:RX_LSB];
  assign ry = ir_q[RY_MSB:RY_LSB];

  // The immediate itself is routed to the bus by the datapath; only its drive strobe lives here.
  logic unused_imm_bits;
  assign unused_imm_bits = ^ir_q[RY_LSB-1:IMM_LSB];

`ifdef CPU_SEQ_STALL_EN
  assign stall_w = stall;
`else
  assign stall_w = 1'b0;
`endif

  // Accept is gated by resetn so no PC increment is signalled while reset is asserted.
  assign accept = (state_q == S_FETCH) && instr_valid && !stall_w && resetn;

  always_comb begin
    state_d     = state_q;
    ir_d        = ir_q;
    instr_ready = 1'b0;
    pc_inc      = 1'b0;
    rin_en      = 1'b0;
    rout_en     = 1'b0;
    rout_sel    = rx;
    ain         = 1'b0;
    gin         = 1'b0;
    gout        = 1'b0;
    pcin        = 1'b0;
    immout      = 1'b0;
    addsub      = 1'b0;
    xorctrl     = 1'b0;
    done        = 1'b0;
    halted      = 1'b0;

    if (!stall_w) begin
      case (state_q)
        S_FETCH: begin
          instr_ready = 1'b1;
          if (accept) begin
            ir_d    = instr;
            pc_inc  = 1'b1;
            state_d = S_T1;
          end
        end

        S_T1: begin
          case (op)
            OP_MV: begin
              rout_en  = 1'b1;
              rout_sel = ry;
              rin_en   = 1'b1;
              done     = 1'b1;
              state_d  = S_FETCH;
            end
            OP_MVI: begin
              immout  = 1'b1;
              rin_en  = 1'b1;
              done    = 1'b1;
              state_d = S_FETCH;
            end
            OP_ADD, OP_SUB, OP_XOR: begin
              rout_en = 1'b1;
              ain     = 1'b1;
              state_d = S_T2;
            end
            OP_JR: begin
              rout_en = 1'b1;
              pcin    = 1'b1;
              done    = 1'b1;
              state_d = S_FETCH;
            end
            OP_HALT: begin
              done    = 1'b1;
              state_d = S_HALT;
            end
            default: begin
              done    = 1'b1;
              state_d = S_FETCH;
            end
          endcase
        end

        // Only ALU ops reach T2/T3; the guard keeps a corrupted state from issuing strobes.
        S_T2: begin
          if (is_alu_op(op)) begin
            rout_en  = 1'b1;
            rout_sel = ry;
            gin      = 1'b1;
            addsub   = (op == OP_SUB);
            xorctrl  = (op == OP_XOR);
            state_d  = S_T3;
          end else begin
            state_d = S_FETCH;
          end
        end

        S_T3: begin
          gout    = 1'b1;
          rin_en  = 1'b1;
          done    = 1'b1;
          state_d = S_FETCH;
        end

        S_HALT: begin
          halted = 1'b1;
        end

        default: begin
          state_d = S_FETCH;
        end
      endcase
    end
  end

  dec3to8 #(.NOUT(NREG)) u_dec_rin (
    .en  (rin_en),
    .sel (rx),
    .y   (rin)
  );

  dec3to8 #(.NOUT(NREG)) u_dec_rout (
    .en  (rout_en),
    .sel (rout_sel),
    .y   (rout)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_FETCH;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
    end
  end

endmodule

// File: tb/tb_cpu_seq_ctrl.sv
// Self-checking bench for cpu_seq_ctrl: per-cycle expected strobe vectors queued from an opcode table.
module tb_cpu_seq_ctrl;

  logic        clk;
  logic        resetn;
  logic [15:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic        pc_inc;
  logic [7:0]  rin;
  logic [7:0]  rout;
  logic        ain;
  logic        gin;
  logic        gout;
  logic        pcin;
  logic        immout;
  logic        addsub;
  logic        xorctrl;
  logic        done;
  logic        halted;

  int checks   = 0;
  int failures = 0;

  logic [26:0] exp_q[$];
  string       tag_q[$];
  logic [26:0] obs_vec;

  cpu_seq_ctrl #(.IW(16), .NREG(8)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .instr       (instr),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .pc_inc      (pc_inc),
    .rin         (rin),
    .rout        (rout),
    .ain         (ain),
    .gin         (gin),
    .gout        (gout),
    .pcin        (pcin),
    .immout      (immout),
    .addsub      (addsub),
    .xorctrl     (xorctrl),
    .done        (done),
    .halted      (halted)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  assign obs_vec = {instr_ready, pc_inc, rin, rout, ain, gin, gout, pcin,
                    immout, addsub, xorctrl, done, halted};

  // Packs one cycle of expected outputs in the same order as obs_vec.
  function automatic logic [26:0] mk(input logic rdy, input logic pci, input logic [7:0] ri,
                                     input logic [7:0] ro, input logic a, input logic gi,
                                     input logic go, input logic pi, input logic im,
                                     input logic as, input logic xc, input logic dn,
                                     input logic hl);
    return {rdy, pci, ri, ro, a, gi, go, pi, im, as, xc, dn, hl};
  endfunction

  function automatic logic [7:0] oh(input logic [2:0] r);
    logic [7:0] v;
    v = 8'h00;
    v[r] = 1'b1;
    return v;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=%h expected=%h @%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic pushExp(input string tag, input logic [26:0] v);
    exp_q.push_back(v);
    tag_q.push_back(tag);
  endtask

  // Expected cycle-by-cycle behaviour of one instruction, starting with its accept cycle.
  task automatic pushModel(input logic [15:0] ins);
    logic [2:0] op, rx, ry;
    op = ins[15:13];
    rx = ins[12:10];
    ry = ins[9:7];
    pushExp("accept", mk(1, 1, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    case (op)
      3'b000: pushExp("mv_t1",   mk(0, 0, oh(rx), oh(ry), 0, 0, 0, 0, 0, 0, 0, 1, 0));
      3'b001: pushExp("mvi_t1",  mk(0, 0, oh(rx), 8'h00, 0, 0, 0, 0, 1, 0, 0, 1, 0));
      3'b101: pushExp("jr_t1",   mk(0, 0, 8'h00, oh(rx), 0, 0, 0, 1, 0, 0, 0, 1, 0));
      3'b110: pushExp("halt_t1", mk(0, 0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 0, 1, 0));
      3'b111: pushExp("nop_t1",  mk(0, 0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 0, 1, 0));
      default: begin
        pushExp("alu_t1", mk(0, 0, 8'h00, oh(rx), 1, 0, 0, 0, 0, 0, 0, 0, 0));
        pushExp("alu_t2", mk(0, 0, 8'h00, oh(ry), 0, 1, 0, 0, 0,
                             op == 3'b011, op == 3'b100, 0, 0));
        pushExp("alu_t3", mk(0, 0, oh(rx), 8'h00, 0, 0, 1, 0, 0, 0, 0, 1, 0));
      end
    endcase
  endtask

  task automatic popAndCheck();
    logic [26:0] e;
    string       t;
    int          bus_drivers;
    if (exp_q.size() == 0) begin
      checkOutput("scoreboard_empty", 32'(obs_vec), 32'h0);
    end else begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      checkOutput(t, 32'(obs_vec), 32'(e));
    end
    bus_drivers = $countones(rout) + int'(gout) + int'(immout);
    checkOutput("bus_excl", 32'(bus_drivers <= 1), 32'h1);
  endtask

  // Drives one instruction and keeps instr_valid high with junk on instr during later steps.
  task automatic applyStimulus(input logic [15:0] ins);
    int n;
    pushModel(ins);
    n = exp_q.size();
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      instr_valid = 1'b1;
      instr       = (i == 0) ? ins : 16'(~ins ^ 16'(i * 16'h1357));
      #1;
      popAndCheck();
    end
  endtask

  task automatic idleCycle(input string tag);
    @(negedge clk);
    instr_valid = 1'b0;
    #1;
    pushExp(tag, mk(1, 0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    popAndCheck();
  endtask

  task automatic resetPulse();
    resetn = 1'b0;
    #1;
    pushExp("in_reset", mk(1, 0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    popAndCheck();
    @(posedge clk);
    @(negedge clk);
    resetn      = 1'b1;
    instr_valid = 1'b0;
    #1;
    pushExp("after_reset", mk(1, 0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    popAndCheck();
  endtask

  initial begin
    logic [15:0] r;
    logic [2:0]  rop;

    resetn      = 1'b0;
    instr_valid = 1'b1;
    instr       = 16'h2955;
    #2;
    pushExp("reset_state", mk(1, 0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    popAndCheck();
    @(negedge clk);
    @(negedge clk);
    resetn      = 1'b1;
    instr_valid = 1'b0;
    #1;
    pushExp("release", mk(1, 0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    popAndCheck();

    applyStimulus(16'h2955);   // MVI r2,#0x155
    idleCycle("idle_mvi");
    applyStimulus(16'h1580);   // MV r5,r3
    applyStimulus(16'h6700);   // SUB r1,r6
    applyStimulus(16'h4E00);   // ADD r3,r4
    applyStimulus(16'hA400);   // JR r1
    applyStimulus(16'h8000);   // XOR r0,r0
    applyStimulus(16'hE000);   // NOP, accepted right after XOR done
    idleCycle("idle_b2b");

    for (int i = 0; i < 24; i++) begin
      r   = 16'($urandom);
      rop = 3'($urandom_range(0, 7));
      if (rop == 3'b110) rop = 3'b111;
      applyStimulus({rop, r[12:0]});
    end
    idleCycle("idle_rand");

    // Reset asserted during T2 of ADD r3,r4 must kill the instruction without done.
    pushModel(16'h4E00);
    void'(exp_q.pop_back());
    void'(tag_q.pop_back());
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      instr_valid = (i == 0);
      instr       = 16'h4E00;
      #1;
      popAndCheck();
    end
    #1;
    resetPulse();
    idleCycle("post_abort_1");
    idleCycle("post_abort_2");

    applyStimulus(16'hC000);   // HALT
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      instr_valid = 1'b1;
      instr       = 16'h2955;
      #1;
      pushExp("halted", mk(0, 0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 0, 0, 1));
      popAndCheck();
    end
    #1;
    resetPulse();
    applyStimulus(16'h1580);
    idleCycle("final_idle");

    checkOutput("scoreboard_drained", 32'(exp_q.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cpu_seq_ctrl.md
Name: cpu_seq_ctrl

Overview:
- Multicycle control sequencer for the 16-bit bus-based CPU datapath.
- Accepts one instruction per handshake and latches it into an internal IR.
- Steps through timesteps T0..T3 and drives the datapath strobes: register in/out enables, A/G load, G/PC/immediate bus drive, add/sub and XOR select.
- Sits between instruction memory and the register file/ALU/PC; it is the only owner of the shared bus drive enables.

Parameters:
- IW, 16, instruction width. Field positions are fixed for 16.
- NREG, 8, number of general registers. Width of rin and rout; must equal 2^3.

Ports:
- clk  in  1  clock, rising edge
- resetn  in  1  asynchronous active-low reset
- instr  in  IW  instruction word from memory
- instr_valid  in  1  instr is valid this cycle
- instr_ready  out  1  sequencer accepts instr this cycle (FETCH state)
- pc_inc  out  1  one-cycle pulse on instruction acceptance; PC += 1
- rin  out  NREG  one-hot register load enable
- rout  out  NREG  one-hot register bus drive enable
- ain  out  1  A (ALU operand) register load
- gin  out  1  G (ALU result) register load
- gout  out  1  G drives bus
- pcin  out  1  PC loads from bus
- immout  out  1  zero-extended instr[9:0] drives bus
- addsub  out  1  0 = add, 1 = subtract
- xorctrl  out  1  1 = ALU performs XOR (overrides addsub)
- done  out  1  one-cycle pulse in the final step of each instruction
- halted  out  1  sequencer is in HALT

Behaviour:
- Fields: opcode = instr[15:13], rx = instr[12:10], ry = instr[9:7], imm = instr[9:0].
- Opcodes:
  - 000 MV rx,ry
  - 001 MVI rx,#imm
  - 010 ADD
  - 011 SUB
  - 100 XOR
  - 101 JR rx
  - 110 HALT
  - 111 NOP
- States: FETCH, T1, T2, T3, HALT. State and IR are registered. All strobes are combinational decode of state+IR (Moore); there is no glitch requirement beyond this.
- FETCH:
  - instr_ready = 1, all other strobes 0.
  - On instr_valid & instr_ready: IR <= instr, pc_inc = 1 in the same cycle, go to T1.
  - Otherwise stay in FETCH.
- T1:
  - MV: rout[ry], rin[rx], done; then FETCH.
  - MVI: immout, rin[rx], done; then FETCH.
  - ADD/SUB/XOR: rout[rx], ain; then T2.
  - JR: rout[rx], pcin, done; then FETCH.
  - NOP: done only; then FETCH.
  - HALT: done; then HALT.
- T2 (ALU ops only): rout[ry], gin; addsub = (op==SUB); xorctrl = (op==XOR); then T3.
- T3: gout, rin[rx], done; then FETCH.
- HALT: all strobes 0, halted = 1, instr_ready = 0. Leaves HALT only on reset.
- Bus exclusivity: at most one of {any rout bit, gout, immout} is high in any cycle. rx == ry is legal; rout/rin target the same register.
- Latency:
  - MV/MVI/JR/NOP/HALT: 2 cycles including fetch.
  - ALU ops: 4 cycles.
  - Back-to-back instr_valid gives a new accept on the cycle after done.
- Reset (async assert, sync release):
  - State = FETCH, IR = 0.
  - Every strobe, done, halted and pc_inc = 0.
  - instr_ready = 1 while in FETCH, including directly after release.
  - Reset mid-instruction aborts it; no done is issued.
- instr is sampled only on accept; changes of instr during T1..T3 have no effect.

Optional Feature:
- Macro CPU_SEQ_STALL_EN adds input port stall (1 bit).
- With the macro defined, stall = 1 holds state and IR and forces every output to 0, including instr_ready, pc_inc and done. Release resumes the same step next cycle.
- Without the macro, the port is absent and the sequencer never stalls.

Decomposition:
- Package cpu_pkg holds:
  - opcode localparams (OP_MV..OP_NOP)
  - state encoding (S_FETCH, S_T1, S_T2, S_T3, S_HALT)
  - field bit-position constants
- Sub-module dec3to8: combinational 3-to-8 one-hot decoder with enable. Instantiated twice, for rin (rx) and rout (rx/ry mux).

Test Plan:
- MVI r2,#0x155 (instr = 0x2955) after reset -> accept cycle pc_inc = 1; next cycle immout = 1, rin = 0x04, done = 1; then instr_ready = 1.
- MV r5,r3 (0x1580) -> T1: rout = 0x08, rin = 0x20, done = 1; no other strobe.
- SUB r1,r6 (0x6700):
  - T1: rout = 0x02, ain = 1
  - T2: rout = 0x40, gin = 1, addsub = 1, xorctrl = 0
  - T3: gout = 1, rin = 0x02, done = 1
  - Total 4 cycles.
- XOR r0,r0 with instr_valid held high back-to-back with NOP -> xorctrl = 1 in T2; NOP is accepted the cycle after the XOR done.
- HALT (0xC000) then instr_valid = 1 -> done in T1, halted = 1 thereafter, instr_ready = 0; pulsing resetn low returns to FETCH.
- resetn low during T2 of ADD -> all strobes 0 immediately (async), no done; FETCH with instr_ready = 1 after release.
